// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
//   Shift-and-add multiplier controller sharing an external 32-bit
//   carry-lookahead adder (cla32, instantiated by the parent). Each RUN cycle
//   presents one partial-product add on addA/addB/addCin. The {hi,lo} pair is
//   shifted right by one as the sum comes back. After WIDTH steps the full
//   2*WIDTH-bit product is left in {hi,lo}.
//
//   Build option: define SIGNED_MUL_EN for a two's-complement multiply.
//   The last step then subtracts the multiplicand when the multiplier sign
//   bit is set, and the shift-in bit becomes the true sign of the (WIDTH+1)-bit
//   sum. Ports and latency are the same in both builds.
//
// Ports
//   clk, rst      clock; synchronous active-low reset
//   start         request, sampled only while the FSM is IDLE
//   a, b          multiplicand / multiplier, captured on an accepted start
//   busy          high while the FSM is in RUN or DONE
//   done          one-cycle pulse; product is valid in that cycle
//   product       {hi,lo}; held until the next accepted start
//   addA, addB    adder operands (both zero outside RUN)
//   addCin        adder carry-in
//   addSum        adder sum (returned from cla32)
//   addCout       adder carry-out (returned from cla32)
//   stateDbg      current FSM state, for debug and checker binding
//
// Handshake: start is a level request with no ready signal. It is taken on
// the first rising edge where the FSM is IDLE; starts seen in RUN or DONE are
// dropped, not queued. done is a single-cycle strobe and has no
// acknowledgement. An accepted start at edge 0 gives done during the cycle
// after edge WIDTH+1. Holding start high gives one multiply every WIDTH+2
// cycles.
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   addA,
  output logic [WIDTH-1:0]   addB,
  output logic               addCin,
  input  logic [WIDTH-1:0]   addSum,
  input  logic               addCout,
  output logic [1:0]         stateDbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] count;
  logic             op;
  logic             lastStep;
  logic             top;

  // The multiplier drains out of lo[0]. Product bits shift in at the top of lo.
  assign op       = lo[0];
  assign lastStep = (count == LAST_STEP);
  assign product  = {hi, lo};
  assign stateDbg = state;

  always_comb begin
    addA   = '0;
    addB   = '0;
    addCin = 1'b0;
    if (state == RUN) begin
      addA = hi;
`ifdef SIGNED_MUL_EN
      // The multiplier sign bit has weight -2^(WIDTH-1). On the last step
      // add ~mcand + 1 (i.e. subtract mcand) instead of mcand.
      if (op) begin
        addB   = lastStep ? ~mcand : mcand;
        addCin = lastStep;
      end
`else
      addB = op ? mcand : '0;
`endif
    end
  end

`ifdef SIGNED_MUL_EN
  // Sign of the (WIDTH+1)-bit signed sum hi + addB (+cin). When op is 0,
  // addB is 0 and no carry occurs, so this reduces to hi[WIDTH-1]
  // (sign extension). The same expression therefore covers every step.
  assign top = addB[WIDTH-1] ^ hi[WIDTH-1] ^ addCout;
`else
  assign top = addCout;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            count <= '0;
          end
        end
        RUN: begin
          {hi, lo} <= {top, addSum, lo[WIDTH-1:1]};
          count    <= count + 1'b1;
          if (lastStep) begin
            state <= DONE;
          end
        end
        DONE: begin
          // The strobe is registered, so it appears as the FSM returns to IDLE.
          // That is the cycle in which a held start can already be taken.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
